serial_tx: RTL and testbench
============================

# serial_tx

Parallel-in, serial-out frame transmitter: captures a WIDTH-bit word on a load strobe and shifts it out on a single line as start bit, data LSB-first, optional even-parity bit, and stop bit, each held for DIV clocks. It is the sending end of the lab's serial link, driving the line that the flip-flop-based receive shift chain samples. All outputs are registered, built on the same asynchronous active-low reset flip-flop style as the rest of the design.

## Interface
- WIDTH, 8, data bits per frame (≥1)
- DIV, 4, clock cycles per transmitted bit (≥1)

- c  input  1  clock; all state changes on posedge c
- rst  input  1  asynchronous, active-low reset
- data  input  WIDTH  word to send; sampled only on an accepted load
- load  input  1  request to start a frame; accepted only when busy=0
- tx  output  1  serial line; idle high
- busy  output  1  high while a frame is in progress
- done  output  1  one-cycle pulse after the stop bit completes

## Operation
- The clock is c. Reset rst is asynchronous and active-low: rst=0 forces state=IDLE, tx=1, busy=0, done=0, shift register=0, bit counter=0, divider=0 immediately, independent of c.
- States: IDLE, START, DATA, PARITY (only with macro), STOP.
- IDLE: tx=1, busy=0. If load=1 at a posedge, capture data into the shift register and enter START. On the same edge, set busy=1, set tx=0, and clear the divider.
- Each non-IDLE state lasts exactly DIV cycles, counted by the divider from 0 to DIV-1. Advance on the edge where divider=DIV-1.
- START -> DATA: tx=shift[0].
- DATA: on each bit boundary, shift right and increment the bit counter. After WIDTH bits, go to PARITY (tx = XOR of captured word) or, without the macro, to STOP (tx=1).
- PARITY -> STOP: tx=1.
- STOP -> IDLE: busy=0, done=1 for exactly one cycle.
- load while busy=1 is ignored: no capture and no effect on the frame in flight.
- The data input may change freely after the accepted load edge.
- Divider width is max(1,$clog2(DIV)). Bit counter width is max(1,$clog2(WIDTH+1)). No wrap-around may occur within a frame.
- Reset mid-frame aborts the frame: tx returns to 1 at once. No done pulse is produced.

## Timing
- Load accepted at edge k: tx=0 during cycles k..k+DIV-1 after that edge.
- Data bit i (LSB i=0) is driven after edge k+(1+i)·DIV.
- Frame length F = (WIDTH+2)·DIV cycles, or (WIDTH+3)·DIV with parity.
- busy is high from edge k to edge k+F. done is high for the cycle following edge k+F.
- Back-to-back: a load asserted while done=1 (state IDLE) is accepted. The next start bit begins at edge k+F+1, giving a minimum of 1 idle-high cycle between frames.
- load and rst deassertion in the same cycle: rst takes priority. The load is not accepted.

## Configuration
- SERIAL_TX_PARITY_EN defined: the PARITY state is compiled in. One even-parity bit (XOR of the WIDTH data bits) is sent between the last data bit and the stop bit, and F grows by DIV.
- SERIAL_TX_PARITY_EN undefined: the PARITY state and its logic are absent, and DATA goes directly to STOP.

## Test plan
- Reset: hold rst=0 with load=1 and data toggling -> tx=1, busy=0, done=0 throughout. Assert rst asynchronously between edges -> outputs reset before the next edge.
- WIDTH=8, DIV=4, no macro, load data=0xA5 at edge 0 -> tx holds 0,1,0,1,0,0,1,0,1,1 for 4 cycles each. busy=1 for edges 0..40. done=1 for exactly one cycle after edge 40.
- Same stimulus with SERIAL_TX_PARITY_EN and data=0xA7 (5 ones) -> parity bit 1 during cycles 36..39, stop 40..43, done after edge 44. With data=0xA5 -> parity bit 0.
- load pulses and data=0xFF at edges 5 and 20 during a 0x3C frame -> the transmitted frame is unchanged (0x3C) and no second frame follows.
- Back-to-back: hold load=1 with data=0x01 then 0x80 -> second start bit begins exactly one cycle after the first done pulse. Both frames are bit-exact.
- Pull rst=0 at cycle 17 of a frame, release at cycle 20 with load=0 -> tx=1 from the rst fall onward, busy=0, no done pulse. A subsequent load transmits a correct full frame.

Source files
------------

// File: rtl/serial_tx.sv
// Parallel-in, serial-out frame transmitter: start bit, LSB-first data, optional
// even parity (macro SERIAL_TX_PARITY_EN), stop bit, each held for DIV clocks.
module serial_tx #(
    parameter int WIDTH = 8,
    parameter int DIV   = 4
) (
    input  logic             c,
    input  logic             rst,
    input  logic [WIDTH-1:0] data,
    input  logic             load,
    output logic             tx,
    output logic             busy,
    output logic             done
);
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CW = ($clog2(WIDTH + 1) > 1) ? $clog2(WIDTH + 1) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [CW-1:0] BIT_LAST = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef SERIAL_TX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] shift_d;
    logic [CW-1:0]    cnt_q;
    logic [DW-1:0]    div_q;
    logic [DW-1:0]    div_d;
    logic             tx_q;
    logic             busy_q;
    logic             done_q;
    logic             bit_end;
`ifdef SERIAL_TX_PARITY_EN
    logic             par_q;
`endif

    assign bit_end = (div_q == DIV_LAST);
    assign div_d   = bit_end ? '0 : div_q + 1'b1;
    assign shift_d = shift_q >> 1;

    always_ff @(posedge c or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            div_q   <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            if (state_q != S_IDLE) div_q <= div_d;
            case (state_q)
                S_IDLE: begin
                    if (load) begin
                        shift_q <= data;
                        cnt_q   <= '0;
                        div_q   <= '0;
                        tx_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= S_START;
`ifdef SERIAL_TX_PARITY_EN
                        par_q   <= ^data;
`endif
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        tx_q    <= shift_q[0];
                        state_q <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        shift_q <= shift_d;
                        cnt_q   <= cnt_q + 1'b1;
                        // cnt_q counts bits already completed, so BIT_LAST marks the final data bit
                        if (cnt_q == BIT_LAST) begin
`ifdef SERIAL_TX_PARITY_EN
                            tx_q    <= par_q;
                            state_q <= S_PARITY;
`else
                            tx_q    <= 1'b1;
                            state_q <= S_STOP;
`endif
                        end else begin
                            tx_q <= shift_d[0];
                        end
                    end
                end
`ifdef SERIAL_TX_PARITY_EN
                S_PARITY: begin
                    if (bit_end) begin
                        tx_q    <= 1'b1;
                        state_q <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    if (bit_end) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;
    assign done = done_q;
endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx (WIDTH=8, DIV=4); frame tables cover both parity builds.
`timescale 1ns/1ps
module tb_serial_tx;
    localparam int WIDTH = 8;
    localparam int DIV   = 4;
`ifdef SERIAL_TX_PARITY_EN
    localparam int NB = WIDTH + 3;
`else
    localparam int NB = WIDTH + 2;
`endif
    localparam int F = NB * DIV;

    logic             c    = 1'b0;
    logic             rst  = 1'b0;
    logic             load = 1'b0;
    logic [WIDTH-1:0] data = '0;
    logic             tx;
    logic             busy;
    logic             done;

    int n_chk  = 0;
    int n_fail = 0;

    // Bit j of a sequence is the line level during bit period j of the frame.
    typedef struct {
        logic [7:0]  d;
        logic [10:0] seq_np;
        logic [10:0] seq_p;
        string       name;
    } vec_t;
    vec_t vecs[7];

    serial_tx #(.WIDTH(WIDTH), .DIV(DIV)) dut (
        .c(c), .rst(rst), .data(data), .load(load),
        .tx(tx), .busy(busy), .done(done)
    );

    always #5 c = ~c;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [10:0] pick(input vec_t v);
`ifdef SERIAL_TX_PARITY_EN
        return v.seq_p;
`else
        return v.seq_np;
`endif
    endfunction

    task automatic check_idle(input string name);
        chk({name, " tx"}, tx, 1);
        chk({name, " busy"}, busy, 0);
        chk({name, " done"}, done, 0);
    endtask

    // Presents a load and returns at the negedge of cycle 0 of the frame.
    task automatic start(input logic [7:0] d);
        @(negedge c);
        data = d;
        load = 1'b1;
        @(posedge c);
        @(negedge c);
    endtask

    // Checks a frame from cycle 0 through the done cycle; pa/pb are cycles on
    // which a stray load of 0xFF is pulsed (pa<0 leaves load untouched).
    task automatic check_frame(input logic [10:0] seq, input string name, input int pa, input int pb);
        for (int cyc = 0; cyc < F; cyc++) begin
            if (cyc > 0) @(negedge c);
            if (pa >= 0) begin
                load = (cyc == pa) || (cyc == pb);
                data = load ? 8'hFF : 8'h5A;
            end
            chk($sformatf("%s tx c%0d", name, cyc), tx, seq[cyc / DIV]);
            chk($sformatf("%s busy c%0d", name, cyc), busy, 1);
            chk($sformatf("%s done c%0d", name, cyc), done, 0);
        end
        @(negedge c);
        chk({name, " done pulse"}, done, 1);
        chk({name, " busy end"}, busy, 0);
        chk({name, " tx end"}, tx, 1);
    endtask

    initial begin
        vecs[0] = '{8'hA5, 11'h34A, 11'h54A, "a5"};
        vecs[1] = '{8'hA7, 11'h34E, 11'h74E, "a7"};
        vecs[2] = '{8'h00, 11'h200, 11'h400, "00"};
        vecs[3] = '{8'hFF, 11'h3FE, 11'h5FE, "ff"};
        vecs[4] = '{8'h3C, 11'h278, 11'h478, "3c"};
        vecs[5] = '{8'h01, 11'h202, 11'h602, "01"};
        vecs[6] = '{8'h80, 11'h300, 11'h700, "80"};

        // Held in reset with load high and data toggling
        rst  = 1'b0;
        load = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge c);
            data = ~data;
            check_idle($sformatf("rst hold %0d", i));
        end
        @(negedge c);
        rst  = 1'b1;
        load = 1'b0;
        @(negedge c);
        check_idle("post rst");

        for (int v = 0; v < 4; v++) begin
            start(vecs[v].d);
            check_frame(pick(vecs[v]), vecs[v].name, F + 5, F + 5);
            @(negedge c);
            check_idle({vecs[v].name, " after"});
        end

        // Stray loads during a frame are ignored
        start(vecs[4].d);
        check_frame(pick(vecs[4]), "ign 3c", 5, 20);
        for (int i = 0; i < 6; i++) begin
            @(negedge c);
            check_idle($sformatf("ign tail %0d", i));
        end

        // Back-to-back with load held high
        start(vecs[5].d);
        data = vecs[6].d;
        check_frame(pick(vecs[5]), "b2b 01", -1, -1);
        @(negedge c);
        check_frame(pick(vecs[6]), "b2b 80", F + 5, F + 5);
        @(negedge c);
        check_idle("b2b after");

        // Asynchronous reset mid-frame, between clock edges
        start(vecs[0].d);
        load = 1'b0;
        repeat (17) @(negedge c);
        chk("pre-abort tx", tx, 0);
        #2 rst = 1'b0;
        #1 check_idle("async abort");
        for (int i = 0; i < 3; i++) begin
            @(negedge c);
            check_idle($sformatf("abort hold %0d", i));
        end
        rst  = 1'b1;
        load = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge c);
            check_idle($sformatf("abort tail %0d", i));
        end
        start(vecs[2].d);
        check_frame(pick(vecs[2]), "post abort 00", F + 5, F + 5);
        @(negedge c);
        check_idle("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
